// File: rtl/dpram_fifo_pkg.sv
// Shared sizing helpers for the dual-port-RAM FIFO controller and its output skid.
package dpram_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // RAM occupancy spans 0..DEPTH inclusive, hence one bit beyond the address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int level_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry FIFO-ordered output buffer that absorbs the RAM's registered read latency.
module fifo_out_skid
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] capture_data,
  input  logic                  pop,
  output skid_cnt_t             skid_cnt,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  skid_cnt_t             cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: the two data slots are reset because slot0 drives out_data directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      unique case ({capture, pop})
        2'b10: begin
          if (cnt == skid_cnt_t'(0)) slot0 <= capture_data;
          else                       slot1 <= capture_data;
          cnt <= cnt + skid_cnt_t'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - skid_cnt_t'(1);
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt == skid_cnt_t'(1)) begin
            slot0 <= capture_data;
          end else begin
            slot0 <= slot1;
            slot1 <= capture_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign skid_cnt  = cnt;
  assign head_data = slot0;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM, with a 2-entry output skid.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH+1:0]   level,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                    ovf_err,
  output logic                    udf_err
`endif
);

  localparam int CNT_W = cnt_width(ADDR_WIDTH);
  localparam int LVL_W = level_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(fifo_depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      ram_cnt;
  logic                  rd_pend;
  skid_cnt_t             skid_cnt;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            skid_future;

  // Gating with rst_n keeps both RAM ports idle for the whole reset window.
  assign in_ready = rst_n && (ram_cnt < DEPTH_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Skid occupancy after the next edge if a read were not issued now.
  assign skid_future = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue       = rst_n && (ram_cnt != '0) && (skid_future < 3'd2);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      unique case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      rd_pend <= issue;
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (rd_pend),
    .capture_data (ram_rd_data),
    .pop          (pop),
    .skid_cnt     (skid_cnt),
    .head_data    (out_data)
  );

  assign out_valid = (skid_cnt != skid_cnt_t'(0));
  assign level     = LVL_W'(ram_cnt) + LVL_W'(rd_pend) + LVL_W'(skid_cnt);

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready)  ovf_err <= 1'b1;
      if (out_ready && !out_valid) udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_dpram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf_err;
  logic          udf_err;
`endif

  int checks = 0;
  int errors = 0;
  int pop_count = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
`endif
  );

  // Behavioural RAM: write on the edge, registered read data one cycle later.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Scoreboard: accepted pushes are queued, every pop is compared in order.
  logic [DW-1:0] sb [$];
  logic [DW-1:0] held_data;
  logic [DW-1:0] exp_data;
  bit            stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== held_data) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%0b out_data=%h, required out_valid=1 out_data=%h",
                   out_valid, out_data, held_data);
        end
      end
      if (out_valid && out_ready) begin
        pop_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_order: popped %h, required no pop (scoreboard empty)", out_data);
        end else begin
          exp_data = sb.pop_front();
          if (out_data !== exp_data) begin
            errors++;
            $display("FAIL pop_order: popped %h, required %h", out_data, exp_data);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    ok       = 1'b0;
    for (int t = 0; t < 4 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    bit done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (level == '0 && !out_valid) done = 1'b1;
    end
    tick();
    checks++;
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL %s: level=%0d queued=%0d, required drained with nothing outstanding",
               name, level, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (level !== '0)       begin errors++; $display("FAIL rst_level: got %0d required 0", level); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", ram_wr_en); end
    if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", ram_rd_en); end
    if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
    tick();
  endtask

  task automatic test_single_word();
    in_valid  = 1'b1;
    in_data   = 32'h0000_00A5;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks += 2;
      if (out_valid !== (e == 3)) begin
        errors++;
        $display("FAIL sw_out_valid_e%0d: got %b required %b", e - 1, out_valid, (e == 3));
      end
      if (level !== 6'd1) begin
        errors++;
        $display("FAIL sw_level_e%0d: got %0d required 1", e - 1, level);
      end
      if (e == 3) begin
        checks++;
        if (out_data !== 32'h0000_00A5) begin
          errors++;
          $display("FAIL sw_out_data: got %h required 000000a5", out_data);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (level !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_after_pop: level=%0d out_valid=%b required 0/0", level, out_valid);
    end
    tick();
  endtask

  task automatic test_streaming();
    int            pops = 0;
    int            bubbles = 0;
    bit            seen = 1'b0;
    bit            acc;
    logic [DW-1:0] d = 32'h0000_0100;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (out_valid) begin
        seen = 1'b1;
        pops++;
      end else if (seen) begin
        bubbles++;
      end
      tick();
      if (acc) begin
        d++;
        in_data = d;
      end
    end
    in_valid = 1'b0;
    checks += 2;
    if (pops != 97)   begin errors++; $display("FAIL stream_pops: got %0d required 97", pops); end
    if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d required 0", bubbles); end
    wait_drained("stream_drain");
  endtask

  task automatic test_fill();
    int accepted = 0;
    int p0 = pop_count;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_word(DW'(i), ok);
      if (ok) accepted++;
    end
    @(negedge clk);
    checks += 3;
    if (accepted != 18)    begin errors++; $display("FAIL fill_accepted: got %0d required 18", accepted); end
    if (level !== 6'd18)   begin errors++; $display("FAIL fill_level: got %0d required 18", level); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b required 0", in_ready); end
    tick();
    wait_drained("fill_drain");
    checks++;
    if (pop_count - p0 != 18) begin
      errors++;
      $display("FAIL fill_pops: got %0d required 18", pop_count - p0);
    end
  endtask

  task automatic test_backpressure();
    int            accepted = 0;
    int            p0 = pop_count;
    bit            acc;
    logic [DW-1:0] d = 32'h00BB_0000;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 60; c++) begin
      out_ready = (c % 2) == 1;
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        accepted++;
        d++;
        in_data = d;
      end
    end
    wait_drained("bp_drain");
    checks++;
    if (pop_count - p0 != accepted) begin
      errors++;
      $display("FAIL bp_count: popped %0d required %0d", pop_count - p0, accepted);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push_word(DW'(32'h00C0_0000 + (r << 8) + i), ok);
      @(negedge clk);
      checks++;
      if (level !== 6'd16) begin errors++; $display("FAIL wrap_level_r%0d: got %0d required 16", r, level); end
      tick();
      wait_drained("wrap_drain");
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(DW'(32'h0000_7700 + i), ok);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (level !== 6'd7) begin errors++; $display("FAIL mid_level_pre: got %0d required 7", level); end
    tick();
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    if (level !== '0)       begin errors++; $display("FAIL mid_rst_level: got %0d required 0", level); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    push_word(32'h0000_1234, ok);
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_data !== 32'h0000_1234) begin
          errors++;
          $display("FAIL mid_first_word: got %h required 00001234", out_data);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_timeout: out_valid never rose, required within 10 cycles"); end
    wait_drained("mid_drain");
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    bit ok;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_after_rst: ovf=%b udf=%b required 0/0", ovf_err, udf_err);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) push_word(DW'(32'h00E0_0000 + i), ok);
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL err_ovf_set: got %b required 1", ovf_err); end
    tick();
    wait_drained("err_drain");
    @(negedge clk);
    checks += 2;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL err_ovf_sticky: got %b required 1", ovf_err); end
    if (udf_err !== 1'b1) begin errors++; $display("FAIL err_udf_set: got %b required 1", udf_err); end
    tick();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: ovf=%b udf=%b required 0/0", ovf_err, udf_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_fill();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
